cluster_wakeup_ctrl: RTL and testbench

//   SoC-side counterpart of the cluster clock gate. Runs on the ungated clock.

---
 rtl/cluster_wakeup_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cluster_wakeup_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_wakeup_ctrl.sv
// -----------------------------------------------------------------------------
// cluster_wakeup_ctrl
//
// SoC-side counterpart of the cluster clock gate, clocked by the ungated clock.
// While the cluster is isolated it holds SoC requests and events aimed at the
// cluster. It raises incoming_req_o to wake the cluster and opens the request
// and event path only once isolation has dropped and a settle delay has
// elapsed. incoming_req_o stays high while responses are still outstanding so
// the cluster clock is kept alive until every accepted request is answered.
//
// Ports:
//   clk_i              ungated SoC/cluster clock
//   rstn_i             asynchronous active-low reset
//   isolate_cluster_i  1 = cluster gated/isolated (from the clock gate)
//   incoming_req_o     registered wake/keep-alive request to the clock gate
//   req_valid_i        SoC request valid
//   req_ready_o        SoC request ready (only while the path is open)
//   req_valid_o        request valid into the cluster (only while open)
//   req_ready_i        cluster request ready
//   rsp_done_i         one-cycle pulse: one response returned
//   evt_i              event pulses from the SoC
//   evt_o              event pulses to the cluster
//   wake_err_o         sticky: wake timed out, or response underflow
// -----------------------------------------------------------------------------
module cluster_wakeup_ctrl #(
    parameter int unsigned NB_EVT          = 8,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned WAKE_TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              isolate_cluster_i,
    output logic              incoming_req_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    input  logic              rsp_done_i,
    input  logic [NB_EVT-1:0] evt_i,
    output logic [NB_EVT-1:0] evt_o,
    output logic              wake_err_o
);

    localparam int unsigned OutstW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CntMax = (WAKE_TIMEOUT > SETTLE_CYCLES) ? WAKE_TIMEOUT
                                                                    : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]   WakeLast   = CntW'(WAKE_TIMEOUT - 1);
    localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [OutstW-1:0] OutstMax   = OutstW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        StGated,
        StWake,
        StSettle,
        StOpen
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [OutstW-1:0] outst_q, outst_d;
    logic [NB_EVT-1:0] pend_q, pend_d;
    logic              incoming_req_q, incoming_req_d;
    logic              wake_err_q, wake_err_d;

    logic need;
    logic timeout_hit;
    logic evt_open;
    logic path_open;
    logic accept;
    logic underflow;

    assign need = req_valid_i | (|pend_q);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StGated;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. cnt is shared between the settle delay and the wake
    // timeout and is cleared on every state change.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            StGated: begin
                if (need) begin
                    state_d = StWake;
                end
            end
            StWake: begin
                if (!isolate_cluster_i) begin
                    state_d = StSettle;
                end else if (cnt_q == WakeLast) begin
                    // Hold the count so the error condition stays stable.
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSettle: begin
                if (isolate_cluster_i) begin
                    state_d = StWake;
                end else if (cnt_q == SettleLast) begin
                    state_d = StOpen;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOpen: begin
                if (isolate_cluster_i) begin
                    state_d = need ? StWake : StGated;
                end
            end
            default: begin
                state_d = StGated;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. The path closes combinationally the same cycle isolation
    // rises, so no SoC handshake can complete into an isolated cluster.
    // -------------------------------------------------------------------------
    always_comb begin
        evt_open    = (state_q == StOpen) & ~isolate_cluster_i;
        path_open   = evt_open & (outst_q < OutstMax);
        req_valid_o = path_open & req_valid_i;
        req_ready_o = path_open & req_ready_i;
        evt_o       = evt_open ? pend_q : '0;
    end

    // -------------------------------------------------------------------------
    // Outstanding counter, pending events, keep-alive request and error flag
    // -------------------------------------------------------------------------
    always_comb begin
        accept    = req_valid_o & req_ready_i;
        // A response arriving together with an accept is balanced by it.
        underflow = rsp_done_i & ~accept & (outst_q == '0);

        outst_d = outst_q;
        unique case ({accept, rsp_done_i})
            2'b10:   outst_d = outst_q + OutstW'(1);
            2'b01:   outst_d = (outst_q != '0) ? outst_q - OutstW'(1) : outst_q;
            default: outst_d = outst_q;
        endcase

        // Delivered bits clear, but a same-cycle new pulse keeps its bit set
        // so it goes out on the following cycle.
        pend_d = (evt_open ? '0 : pend_q) | evt_i;

        incoming_req_d = req_valid_i
                       | (|pend_q)
                       | (outst_q != '0)
                       | (state_q inside {StWake, StSettle})
                       | (|evt_i);

        wake_err_d = wake_err_q | timeout_hit | underflow;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outst_q        <= '0;
            pend_q         <= '0;
            incoming_req_q <= 1'b0;
            wake_err_q     <= 1'b0;
        end else begin
            outst_q        <= outst_d;
            pend_q         <= pend_d;
            incoming_req_q <= incoming_req_d;
            wake_err_q     <= wake_err_d;
        end
    end

    assign incoming_req_o = incoming_req_q;
    assign wake_err_o     = wake_err_q;

endmodule

// File: tb/tb_cluster_wakeup_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cluster_wakeup_ctrl. Stimulus pushes hand-computed expected
// output values for the current cycle into a queue; an independent monitor
// pops and compares them against the DUT outputs on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cluster_wakeup_ctrl;

    localparam int IQ = 11;
    localparam int RV = 10;
    localparam int RR = 9;
    localparam int ER = 8;

    typedef struct {
        string       name;
        logic [11:0] val;
        logic [11:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       iso;
    logic       incoming_req;
    logic       rv_i;
    logic       rr_o;
    logic       rv_o;
    logic       rr_i;
    logic       rsp;
    logic [7:0] evt_in;
    logic [7:0] evt_out;
    logic       err;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [11:0] obs;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    cluster_wakeup_ctrl #(
        .NB_EVT          (8),
        .SETTLE_CYCLES   (2),
        .MAX_OUTSTANDING (8),
        .WAKE_TIMEOUT    (64)
    ) dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .isolate_cluster_i (iso),
        .incoming_req_o    (incoming_req),
        .req_valid_i       (rv_i),
        .req_ready_o       (rr_o),
        .req_valid_o       (rv_o),
        .req_ready_i       (rr_i),
        .rsp_done_i        (rsp),
        .evt_i             (evt_in),
        .evt_o             (evt_out),
        .wake_err_o        (err)
    );

    assign obs = {incoming_req, rv_o, rr_o, err, evt_out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_bit(input string name, input int pos, input logic v);
        exp_t e;
        e.name      = name;
        e.val       = '0;
        e.mask      = '0;
        e.val[pos]  = v;
        e.mask[pos] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic exp_evt(input string name, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.val  = {4'b0, v};
        e.mask = 12'h0ff;
        exp_q.push_back(e);
    endtask

    task automatic exp_all(input string name, input logic [11:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        e.mask = 12'hfff;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                n_checks++;
                if ((obs & cur.mask) !== (cur.val & cur.mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h (mask %h) at %0t",
                             cur.name, obs & cur.mask, cur.val & cur.mask, cur.mask, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn   = 1'b0;
        iso    = 1'b1;
        rv_i   = 1'b0;
        rr_i   = 1'b0;
        rsp    = 1'b0;
        evt_in = 8'h00;

        tick();
        exp_all("reset_outputs", 12'h000);

        // Wake sequence: GATED -> WAKE -> SETTLE x2 -> OPEN
        tick();
        rstn = 1'b1;
        rv_i = 1'b1;
        rr_i = 1'b1;
        exp_bit("t1_iq_before", IQ, 1'b0);
        exp_bit("t1_rr_gated", RR, 1'b0);
        tick();
        exp_bit("t1_iq_raised", IQ, 1'b1);
        exp_bit("t1_rr_wake", RR, 1'b0);
        exp_bit("t1_rv_wake", RV, 1'b0);
        tick();
        iso = 1'b0;
        exp_bit("t1_rv_wake_iso_drop", RV, 1'b0);
        tick();
        exp_bit("t1_rv_settle0", RV, 1'b0);
        tick();
        exp_bit("t1_rv_settle1", RV, 1'b0);
        tick();
        exp_bit("t1_rv_open", RV, 1'b1);
        exp_bit("t1_rr_open", RR, 1'b1);
        tick();
        exp_bit("t2_rv_acc2", RV, 1'b1);
        tick();
        exp_bit("t2_rv_acc3", RV, 1'b1);

        // Three outstanding, then three responses
        tick();
        rv_i = 1'b0;
        exp_bit("t2_rv_idle", RV, 1'b0);
        exp_bit("t2_rr_room", RR, 1'b1);
        exp_bit("t2_iq_outst3", IQ, 1'b1);
        tick();
        rsp = 1'b1;
        exp_bit("t2_iq_outst3b", IQ, 1'b1);
        tick();
        tick();
        tick();
        rsp = 1'b0;
        exp_bit("t2_iq_outst_last", IQ, 1'b1);
        tick();
        exp_bit("t2_iq_drop", IQ, 1'b0);
        exp_bit("t2_err_clean", ER, 1'b0);

        // Saturation at MAX_OUTSTANDING
        for (int i = 0; i < 8; i++) begin
            tick();
            rv_i = 1'b1;
            exp_bit($sformatf("t3_rr_acc%0d", i), RR, 1'b1);
            exp_bit($sformatf("t3_rv_acc%0d", i), RV, 1'b1);
        end
        tick();
        rsp = 1'b1;
        exp_bit("t3_rr_saturated", RR, 1'b0);
        exp_bit("t3_rv_saturated", RV, 1'b0);
        tick();
        exp_bit("t3_rv_at7_both", RV, 1'b1);
        exp_bit("t3_rr_at7_both", RR, 1'b1);
        tick();
        rsp  = 1'b0;
        rv_i = 1'b0;
        exp_bit("t3_rr_still7", RR, 1'b1);
        tick();
        rv_i = 1'b1;
        exp_bit("t3_rv_to8", RV, 1'b1);
        tick();
        rv_i = 1'b0;
        exp_bit("t3_rr_full_again", RR, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            rsp = 1'b1;
        end
        tick();
        rsp = 1'b0;
        exp_bit("t3_rr_drained", RR, 1'b1);
        exp_bit("t3_err_clean", ER, 1'b0);
        exp_bit("t3_iq_last", IQ, 1'b1);
        tick();
        exp_bit("t3_iq_drop", IQ, 1'b0);

        // Events held while isolated, delivered once open
        tick();
        iso = 1'b1;
        exp_bit("t4_rr_closed", RR, 1'b0);
        exp_evt("t4_evt_closed", 8'h00);
        tick();
        evt_in = 8'h05;
        exp_evt("t4_evt_gated", 8'h00);
        exp_bit("t4_iq_before_evt", IQ, 1'b0);
        tick();
        evt_in = 8'h04;
        exp_bit("t4_iq_evt", IQ, 1'b1);
        exp_evt("t4_evt_gated2", 8'h00);
        tick();
        evt_in = 8'h00;
        iso    = 1'b0;
        exp_evt("t4_evt_wake", 8'h00);
        tick();
        exp_evt("t4_evt_settle0", 8'h00);
        tick();
        exp_evt("t4_evt_settle1", 8'h00);
        tick();
        evt_in = 8'h01;
        exp_evt("t4_evt_deliver", 8'h05);
        tick();
        evt_in = 8'h00;
        exp_evt("t4_evt_next", 8'h01);
        tick();
        exp_evt("t4_evt_cleared", 8'h00);

        // Isolation during OPEN, then wake timeout
        tick();
        rv_i = 1'b1;
        iso  = 1'b1;
        exp_bit("t6_rv_closed", RV, 1'b0);
        exp_bit("t6_rr_closed", RR, 1'b0);
        tick();
        rv_i = 1'b0;
        exp_bit("t6_iq_wake", IQ, 1'b1);
        exp_bit("t6_rv_wake", RV, 1'b0);
        exp_bit("t5_err_start", ER, 1'b0);
        for (int i = 1; i < 63; i++) begin
            tick();
        end
        tick();
        exp_bit("t5_err_before", ER, 1'b0);
        tick();
        exp_bit("t5_err_set", ER, 1'b1);
        tick();
        iso = 1'b0;
        exp_bit("t5_err_sticky", ER, 1'b1);
        exp_bit("t5_iq_wake", IQ, 1'b1);

        // Asynchronous reset in SETTLE, then response underflow
        tick();
        #1;
        rstn = 1'b0;
        exp_all("t6_async_reset", 12'h000);
        tick();
        rstn = 1'b1;
        exp_bit("t6_iq_after_reset", IQ, 1'b0);
        exp_bit("t6_err_after_reset", ER, 1'b0);
        tick();
        rsp = 1'b1;
        exp_bit("t5_err_pre_underflow", ER, 1'b0);
        tick();
        rsp = 1'b0;
        exp_bit("t5_err_underflow", ER, 1'b1);
        exp_bit("t5_rr_gated", RR, 1'b0);
        tick();
        exp_bit("t5_err_underflow_sticky", ER, 1'b1);

        @(negedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL final_err: got %b, expected 1", err);
        end
        n_checks++;
        if (incoming_req !== 1'b0) begin
            n_fail++;
            $display("FAIL final_iq: got %b, expected 0", incoming_req);
        end
        n_checks++;
        if (rv_o !== 1'b0) begin
            n_fail++;
            $display("FAIL final_rv: got %b, expected 0", rv_o);
        end
        n_checks++;
        if (rr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL final_rr: got %b, expected 0", rr_o);
        end
        n_checks++;
        if (evt_out !== 8'h00) begin
            n_fail++;
            $display("FAIL final_evt: got %h, expected 00", evt_out);
        end
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL too few checks evaluated: %0d", n_checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
